vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator for the display path; supersedes the fixed 640x480 controller. Produces pixel and character-cell coordinates for the upstream framebuffer/text-mode fetch logic. It also re-aligns sync, blanking and colour to a configurable fetch latency and supports a pixel-clock enable for running from a faster system clock. Sits between the video memory/font ROM pipeline and the board VGA pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10; V_SYNC, 2; V_BP, 33, vertical porch/sync widths (lines)
- HS_POL, 0, hsync active level; VS_POL, 0, vsync active level
- CELL_W, 8, character cell width (1..16); CELL_H, 16, cell height (1..16)
- DATA_LAT, 1, pix_en cycles from address out to vga_data in (0..4)
- ADDR_W, 10, width of h_addr/v_addr/char_col/char_row; CW, 8, bits per colour channel

Ports:
- pclk  in  1  clock
- resetn  in  1  reset; **one clock; reset is asynchronous and active-low**
- pix_en  in  1  pixel strobe; all state advances only when high
- vga_data  in  3*CW  {R,G,B} for the pixel addressed DATA_LAT strobes earlier
- h_addr, v_addr  out  ADDR_W  active-area pixel coordinate, 0 outside active
- char_col, char_row  out  ADDR_W  cell index (h_addr/CELL_W, v_addr/CELL_H)
- cell_x, cell_y  out  4  offset inside cell (h_addr%CELL_W, v_addr%CELL_H)
- addr_valid  out  1  address stage is in active area
- line_start, frame_start  out  1  address stage at h_cnt==0 / h_cnt==0&&v_cnt==0
- hsync, vsync  out  1  sync, aligned to colour output
- valid  out  1  colour output is an active pixel
- vga_r, vga_g, vga_b  out  CW  colour, forced 0 when valid low

## Operation
- h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), order: active, FP, sync, BP; v_cnt likewise over lines; v_cnt increments when h_cnt wraps; both wrap to 0 after (H_TOTAL-1, V_TOTAL-1).
- Raw sync: hsync active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync same on v_cnt; inactive level = ~POL.
- addr_valid = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; h_addr = h_cnt when h_cnt<H_ACTIVE else 0; v_addr similarly.
- Cell coordinates from incrementing counters, no dividers: cell_x increments with h_addr, wraps at CELL_W-1 and bumps char_col; both clear at h_cnt wrap. cell_y/char_row identically per line, cleared at frame wrap. Outside active area char/cell outputs hold 0.
- Non-multiple widths: last partial cell counts normally (e.g. H_ACTIVE=100, CELL_W=8 → char_col reaches 12, cell_x reaches 3).
- Delay line of DATA_LAT stages carries {raw hsync, raw vsync, addr_valid}, advancing on pix_en only; output register captures delayed flags and vga_data (masked to 0 if delayed valid is 0).
- pix_en low: counters, delay line and output registers hold; frame_start/line_start deasserted.

## Timing
- Reset (async assert, sync release by pclk): counters 0, delay line cleared to inactive sync/valid 0; h_addr=v_addr=char/cell=0, addr_valid=1 (state 0,0), hsync=~HS_POL, vsync=~VS_POL, valid=0, colour 0, line_start=frame_start=0.
- Address outputs are registered counters: reflect current (h_cnt,v_cnt) state.
- Output latency: hsync/vsync/valid/colour describe the pixel whose address appeared DATA_LAT+1 pix_en strobes earlier.
- line_start/frame_start high for exactly the pclk cycles where state matches and pix_en=1 (one cycle per line/frame with pix_en tied high).
- Reset mid-frame: everything returns to reset values immediately; first frame_start on first pix_en after release.

## Test plan
- Defaults, pix_en=1: line period 800 pclk, frame 420000 pclk; hsync low for 96 cycles starting 656+DATA_LAT+1 cycles after line_start; vsync low for lines 490-491.
- Defaults: at h_addr=639,v_addr=479 → char_col=79, cell_x=7, char_row=29, cell_y=15; next strobe → addr_valid=0, all coordinates 0.
- DATA_LAT=3, vga_data=h_addr-derived pattern: vga_r on output equals the low byte of the h_addr presented 4 strobes earlier; colour 0 throughout blanking.
- pix_en toggling 1-of-4: all periods scale x4, frame_start one pclk wide, outputs stable while pix_en=0.
- H_ACTIVE=100, CELL_W=8, HS_POL=1: char_col max 12, cell_x max 3, hsync high for H_SYNC cycles.
- Assert resetn low mid-line at h_cnt=300: outputs reach reset values within that cycle; after release frame_start precedes first valid by DATA_LAT+1 strobes.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with character-cell coordinates
// and sync/colour realignment to the pixel fetch latency.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CELL_W   = 8,
    parameter int unsigned CELL_H   = 16,
    parameter int unsigned DATA_LAT = 1,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CW       = 8
) (
    input  logic              pclk,
    input  logic              resetn,
    input  logic              pix_en,
    input  logic [3*CW-1:0]   vga_data,
    output logic [ADDR_W-1:0] h_addr,
    output logic [ADDR_W-1:0] v_addr,
    output logic [ADDR_W-1:0] char_col,
    output logic [ADDR_W-1:0] char_row,
    output logic [3:0]        cell_x,
    output logic [3:0]        cell_y,
    output logic              addr_valid,
    output logic              line_start,
    output logic              frame_start,
    output logic              hsync,
    output logic              vsync,
    output logic              valid,
    output logic [CW-1:0]     vga_r,
    output logic [CW-1:0]     vga_g,
    output logic [CW-1:0]     vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);
    localparam int unsigned DL      = (DATA_LAT > 0) ? DATA_LAT : 1;
    localparam logic [2:0]  IDLE    = {~HS_POL, ~VS_POL, 1'b0};

    logic [HCW-1:0]    h_cnt;
    logic [VCW-1:0]    v_cnt;
    logic [3:0]        cx, cy;
    logic [ADDR_W-1:0] col, row;
    logic              h_act, v_act, h_wrap, v_wrap;
    logic              hs_raw, vs_raw;
    logic [2:0]        raw_flags, del_flags;
    logic [2:0]        dly [DL];

    assign h_act  = h_cnt < HCW'(H_ACTIVE);
    assign v_act  = v_cnt < VCW'(V_ACTIVE);
    assign h_wrap = h_cnt == HCW'(H_TOTAL - 1);
    assign v_wrap = v_cnt == VCW'(V_TOTAL - 1);

    assign hs_raw = (h_cnt >= HCW'(H_ACTIVE + H_FP) &&
                     h_cnt <  HCW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    assign vs_raw = (v_cnt >= VCW'(V_ACTIVE + V_FP) &&
                     v_cnt <  VCW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;

    assign addr_valid  = h_act && v_act;
    assign h_addr      = addr_valid ? ADDR_W'(h_cnt) : '0;
    assign v_addr      = addr_valid ? ADDR_W'(v_cnt) : '0;
    assign char_col    = addr_valid ? col : '0;
    assign char_row    = addr_valid ? row : '0;
    assign cell_x      = addr_valid ? cx : '0;
    assign cell_y      = addr_valid ? cy : '0;
    assign line_start  = resetn && pix_en && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Cell counters track the next state so they line up with h_cnt/v_cnt.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            cx  <= '0;
            col <= '0;
            cy  <= '0;
            row <= '0;
        end else if (pix_en) begin
            if (h_cnt < HCW'(H_ACTIVE - 1)) begin
                if (cx == 4'(CELL_W - 1)) begin
                    cx  <= '0;
                    col <= col + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end else begin
                cx  <= '0;
                col <= '0;
            end
            if (h_wrap) begin
                if (v_cnt < VCW'(V_ACTIVE - 1)) begin
                    if (cy == 4'(CELL_H - 1)) begin
                        cy  <= '0;
                        row <= row + 1'b1;
                    end else begin
                        cy <= cy + 1'b1;
                    end
                end else begin
                    cy  <= '0;
                    row <= '0;
                end
            end
        end
    end

    assign raw_flags = {hs_raw, vs_raw, addr_valid};

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DL; i++) dly[i] <= IDLE;
        end else if (pix_en) begin
            dly[0] <= raw_flags;
            for (int i = 1; i < DL; i++) dly[i] <= dly[i-1];
        end
    end

    assign del_flags = (DATA_LAT == 0) ? raw_flags : dly[DL-1];

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            valid <= 1'b0;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_en) begin
            hsync <= del_flags[2];
            vsync <= del_flags[1];
            valid <= del_flags[0];
            vga_r <= del_flags[0] ? vga_data[3*CW-1:2*CW] : '0;
            vga_g <= del_flags[0] ? vga_data[2*CW-1:CW]   : '0;
            vga_b <= del_flags[0] ? vga_data[CW-1:0]      : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster with
// partial cells, DATA_LAT=3, positive hsync and pixel-strobe gating.
module tb_vga_timing_gen;

    localparam int HA = 20, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int CWD = 8, CHT = 4, LAT = 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vld;
        logic [23:0] rgb;
    } exp_t;

    logic        pclk = 1'b0;
    logic        resetn;
    logic        pix_en;
    logic [23:0] vga_data;
    logic [9:0]  h_addr, v_addr, char_col, char_row;
    logic [3:0]  cell_x, cell_y;
    logic        addr_valid, line_start, frame_start;
    logic        hsync, vsync, valid;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .CELL_W(CWD), .CELL_H(CHT),
        .DATA_LAT(LAT), .ADDR_W(10), .CW(8)
    ) dut (
        .pclk(pclk), .resetn(resetn), .pix_en(pix_en),
        .vga_data(vga_data), .h_addr(h_addr), .v_addr(v_addr),
        .char_col(char_col), .char_row(char_row),
        .cell_x(cell_x), .cell_y(cell_y), .addr_valid(addr_valid),
        .line_start(line_start), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .valid(valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 pclk = ~pclk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          mh, mv;
    bit          mon_on = 1'b0;
    exp_t        exp_q[$];
    logic [23:0] dq[$];
    exp_t        lastexp;
    exp_t        rst_exp;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic bit is_act(int h, int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic exp_t pix_exp(int h, int v);
        exp_t e;
        e.hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? HPOL : !HPOL;
        e.vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? VPOL : !VPOL;
        e.vld = is_act(h, v);
        e.rgb = e.vld ? {h[7:0], v[7:0], 8'h5A} : 24'h0;
        return e;
    endfunction

    function automatic logic [23:0] pix_data(int h, int v);
        return is_act(h, v) ? {h[7:0], v[7:0], 8'h5A} : 24'hFFFFFF;
    endfunction

    task automatic restart();
        mh = 0;
        mv = 0;
        exp_q.delete();
        dq.delete();
        for (int i = 0; i < LAT; i++) exp_q.push_back(rst_exp);
        lastexp = rst_exp;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, {h_addr, v_addr, char_col, char_row}, 32'h0);
        chk({tag, "_cell"}, {cell_x, cell_y}, 32'h0);
        chk({tag, "_addr_valid"}, addr_valid, 1);
        chk({tag, "_starts"}, {line_start, frame_start}, 0);
        chk({tag, "_sync_valid"}, {hsync, vsync, valid}, {!HPOL, !VPOL, 1'b0});
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    endtask

    // One pclk cycle, entered and left on the falling edge.
    task automatic step(input logic en);
        bit a;
        pix_en = en;
        #1;
        a = is_act(mh, mv);
        chk("addr_valid", addr_valid, a);
        chk("h_addr", h_addr, a ? mh : 0);
        chk("v_addr", v_addr, a ? mv : 0);
        chk("char_col", char_col, a ? mh / CWD : 0);
        chk("cell_x", cell_x, a ? mh % CWD : 0);
        chk("char_row", char_row, a ? mv / CHT : 0);
        chk("cell_y", cell_y, a ? mv % CHT : 0);
        chk("line_start", line_start, en && mh == 0);
        chk("frame_start", frame_start, en && mh == 0 && mv == 0);
        if (en) begin
            exp_q.push_back(pix_exp(mh, mv));
            dq.push_back(pix_data(mh, mv));
            vga_data = (dq.size() > LAT) ? dq.pop_front() : 24'hFFFFFF;
        end
        @(posedge pclk);
        if (en) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        @(negedge pclk);
    endtask

    always @(posedge pclk) begin
        logic en;
        if (mon_on) begin
            en = pix_en;
            #1;
            if (en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: actual 0 required 1");
                end else begin
                    lastexp = exp_q.pop_front();
                end
            end
            chk("sync_valid", {hsync, vsync, valid},
                {lastexp.hs, lastexp.vs, lastexp.vld});
            chk("rgb", {vga_r, vga_g, vga_b}, lastexp.rgb);
        end
    end

    initial begin
        rst_exp = '{hs: !HPOL, vs: !VPOL, vld: 1'b0, rgb: 24'h0};
        resetn   = 1'b0;
        pix_en   = 1'b1;
        vga_data = 24'hFFFFFF;
        repeat (3) @(negedge pclk);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        restart();
        mon_on = 1'b1;

        for (int i = 0; i < 300; i++) step(1'b1);
        for (int i = 0; i < 1200; i++) step((i % 4) == 0);

        for (int i = 0; i < 400 && !(mv == 3 && mh == 12); i++) step(1'b1);
        chk("reset_point", (mv == 3 && mh == 12), 1);
        mon_on = 1'b0;
        #2 resetn = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge pclk);
        resetn = 1'b1;
        restart();
        mon_on = 1'b1;
        for (int i = 0; i < 300; i++) step(1'b1);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
